// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Shares the register file's single write port between two
//               writeback requesters (A = ALU/execute, B = load/multicycle).
//               Each requester has a one-entry holding buffer behind a
//               valid/ready handshake. A round-robin arbiter with an age
//               override for same-destination entries drains the buffers
//               into the register file. Per-read-port hazard flags report
//               buffered writes that target a register decode is reading.
// Ports       : clk, reset             clock, synchronous active-high reset
//               a_valid/a_ready/a_wa/a_wd   requester A handshake + payload
//               b_valid/b_ready/b_wa/b_wd   requester B handshake + payload
//               regwrite/wa/wd         register file write port
//               ra1/ra2                decode read addresses
//               hazard1/hazard2        buffered write targets ra1/ra2
// Revision    : 1.0  initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [REGBITS-1:0] a_wa,
    input  logic [WIDTH-1:0]   a_wd,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [REGBITS-1:0] b_wa,
    input  logic [WIDTH-1:0]   b_wd,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    input  logic [REGBITS-1:0] ra1,
    input  logic [REGBITS-1:0] ra2,
    output logic               hazard1,
    output logic               hazard2
);

    localparam logic [REGBITS-1:0] c_R0 = '0;

    // Holding buffers, round-robin pointer (0 favours A) and age bit
    logic               r_a_full;
    logic [REGBITS-1:0] r_a_wa;
    logic [WIDTH-1:0]   r_a_wd;
    logic               r_b_full;
    logic [REGBITS-1:0] r_b_wa;
    logic [WIDTH-1:0]   r_b_wd;
    logic               r_rr;
    logic               r_a_older;

    logic w_a_grant;
    logic w_b_grant;
    logic w_both_full;
    logic w_a_load;
    logic w_b_load;
    logic w_a_stays;
    logic w_b_stays;

    assign w_both_full = r_a_full && r_b_full;

    // Grant is purely a function of buffered state; nothing is granted
    // while reset is high so no write escapes during reset.
    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        if (!reset) begin
            if (w_both_full) begin
                // Same destination: the older entry must commit first so the
                // younger value is the one left in the register file.
                if (r_a_wa == r_b_wa) begin
                    w_a_grant = r_a_older;
                end else begin
                    w_a_grant = !r_rr;
                end
                w_b_grant = !w_a_grant;
            end else begin
                w_a_grant = r_a_full;
                w_b_grant = r_b_full;
            end
        end
    end

    // A buffer being drained this cycle can reload on the same edge
    assign a_ready = !reset && (!r_a_full || w_a_grant);
    assign b_ready = !reset && (!r_b_full || w_b_grant);

    // Writes to register zero complete the handshake but are discarded
    assign w_a_load = a_valid && a_ready && (a_wa != c_R0);
    assign w_b_load = b_valid && b_ready && (b_wa != c_R0);

    // Entry that remains held across the edge (not drained this cycle)
    assign w_a_stays = r_a_full && !w_a_grant;
    assign w_b_stays = r_b_full && !w_b_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_full  <= 1'b0;
            r_a_wa    <= '0;
            r_a_wd    <= '0;
            r_b_full  <= 1'b0;
            r_b_wa    <= '0;
            r_b_wd    <= '0;
            r_rr      <= 1'b0;
            r_a_older <= 1'b1;
        end else begin
            if (w_a_load) begin
                r_a_full <= 1'b1;
                r_a_wa   <= a_wa;
                r_a_wd   <= a_wd;
            end else if (w_a_grant) begin
                r_a_full <= 1'b0;
            end

            if (w_b_load) begin
                r_b_full <= 1'b1;
                r_b_wa   <= b_wa;
                r_b_wd   <= b_wd;
            end else if (w_b_grant) begin
                r_b_full <= 1'b0;
            end

            // Under contention, point at the side that just lost
            if (w_both_full) begin
                r_rr <= w_a_grant;
            end

            // Loads on the same edge count A as older; otherwise the entry
            // that was already waiting is the older one.
            if (w_a_load && w_b_load) begin
                r_a_older <= 1'b1;
            end else if (w_a_load && w_b_stays) begin
                r_a_older <= 1'b0;
            end else if (w_b_load && w_a_stays) begin
                r_a_older <= 1'b1;
            end
        end
    end

    assign regwrite = w_a_grant || w_b_grant;
    assign wa = w_a_grant ? r_a_wa : (w_b_grant ? r_b_wa : c_R0);
    assign wd = w_a_grant ? r_a_wd : (w_b_grant ? r_b_wd : '0);

    // The entry being written this cycle still flags a hazard: the register
    // file only holds the value after this edge.
    assign hazard1 = !reset && (ra1 != c_R0) &&
                     ((r_a_full && (r_a_wa == ra1)) || (r_b_full && (r_b_wa == ra1)));
    assign hazard2 = !reset && (ra2 != c_R0) &&
                     ((r_a_full && (r_a_wa == ra2)) || (r_b_full && (r_b_wa == ra2)));

endmodule
`default_nettype wire
